// File: rtl/dca_matrix_store_row_packer_pkg.sv
// Shared types and helpers for the DCA matrix store-path row packer.
package dca_matrix_store_row_packer_pkg;

   // Packer control states; encodings are visible on debug taps, keep them fixed.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   // Width of a counter/pointer able to index n distinct values (never below 1 bit).
   function automatic int ptr_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dca_matrix_store_row_packer_row_fifo.sv
// Synchronous row buffer between the packer and the AXI write-data path.
// Output data is taken from registers only; while empty it keeps showing the
// most recently popped entry so downstream sees stable values.
module dca_row_fifo
   import dca_matrix_store_row_packer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstnn,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int BW_PTR = ptr_width(DEPTH);
   localparam int BW_CNT = ptr_width(DEPTH + 1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  hold;
   logic [BW_PTR-1:0] wr_ptr;
   logic [BW_PTR-1:0] rd_ptr;
   logic [BW_CNT-1:0] count;
   logic              do_push;
   logic              do_pop;

   function automatic logic [BW_PTR-1:0] next_ptr(input logic [BW_PTR-1:0] p);
      return (p == BW_PTR'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == BW_CNT'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? hold : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; clear and reset both flush the buffer.
   always_ff @(posedge clk) begin
      if (!rstnn || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // Entry storage and the hold copy of the last popped entry (data only, no reset).
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
      if (do_pop)  hold        <= mem[rd_ptr];
   end

endmodule

// File: rtl/dca_matrix_store_row_packer.sv
// Store-path row packer: takes one store command, converts NUM_COL tensor
// scalars per row to LSU element width, applies the column mask as zeroed
// elements and cleared byte strobes, tags the final row and buffers rows
// toward the AXI write-data channel.
module dca_matrix_store_row_packer
   import dca_matrix_store_row_packer_pkg::*;
#(
   parameter int NUM_COL    = 4,
   parameter int BW_SCALAR  = 32,
   parameter int BW_ELEMENT = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int BW_ROW_CNT = 8
) (
   input  logic                              clk,
   input  logic                              rstnn,
   input  logic                              clear,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [BW_ROW_CNT-1:0]             cmd_num_row_m1,
   input  logic [NUM_COL-1:0]                cmd_col_mask,
   input  logic                              cmd_is_signed,
   input  logic                              tin_valid,
   output logic                              tin_ready,
   input  logic [NUM_COL*BW_SCALAR-1:0]      tin_row,
   output logic                              wout_valid,
   input  logic                              wout_ready,
   output logic [NUM_COL*BW_ELEMENT-1:0]     wout_row,
   output logic [NUM_COL*BW_ELEMENT/8-1:0]   wout_strb,
   output logic                              wout_last,
   output logic                              busy,
   output logic [BW_ROW_CNT-1:0]             row_cnt
);

   localparam int BW_STRB_PER_ELEMENT = BW_ELEMENT / 8;
   localparam int BW_PACKED_ROW       = NUM_COL * BW_ELEMENT;
   localparam int BW_STRB             = NUM_COL * BW_STRB_PER_ELEMENT;
   localparam int BW_FIFO_ENTRY       = BW_PACKED_ROW + BW_STRB + 1;
   localparam int BW_WIDE             = (BW_ELEMENT > BW_SCALAR) ? BW_ELEMENT : BW_SCALAR;

   state_t                   state;
   logic [BW_ROW_CNT-1:0]    num_row_m1_q;
   logic [NUM_COL-1:0]       mask_q;
   logic                     is_signed_q;

   logic                     tin_fire;
   logic [BW_PACKED_ROW-1:0] row_p0;
   logic [BW_STRB-1:0]       strb_p0;
   logic                     last_p0;
   logic [BW_FIFO_ENTRY-1:0] entry_p0;
   logic [BW_FIFO_ENTRY-1:0] entry_p1;
   logic                     vld_p1;
   logic                     fifo_full;
   logic                     fifo_empty;

   // Widen with sign or zero fill, or keep the low bits when narrowing.
   function automatic logic [BW_ELEMENT-1:0] conv_scalar(input logic [BW_SCALAR-1:0] s,
                                                        input logic sgn);
      logic [BW_WIDE-1:0] w;
      w = BW_WIDE'(s);
      for (int b = BW_SCALAR; b < BW_WIDE; b++) w[b] = sgn & s[BW_SCALAR-1];
      return w[BW_ELEMENT-1:0];
   endfunction

   assign tin_ready = (state == ST_STREAM) && !fifo_full;
   assign tin_fire  = tin_valid && tin_ready;
   assign last_p0   = (row_cnt == num_row_m1_q);

   // Stage p0: convert the incoming row column by column and build its strobes.
   always_comb begin
      row_p0  = '0;
      strb_p0 = '0;
      for (int c = 0; c < NUM_COL; c++) begin
         if (mask_q[c]) begin
            row_p0[c*BW_ELEMENT +: BW_ELEMENT] =
               conv_scalar(tin_row[c*BW_SCALAR +: BW_SCALAR], is_signed_q);
            strb_p0[c*BW_STRB_PER_ELEMENT +: BW_STRB_PER_ELEMENT] = '1;
         end
      end
   end

   assign entry_p0 = {last_p0, strb_p0, row_p0};

   // Command FSM: latch the command, count accepted rows, wait for the drain.
   always_ff @(posedge clk) begin
      if (!rstnn || clear) begin
         state        <= ST_IDLE;
         row_cnt      <= '0;
         num_row_m1_q <= '0;
         mask_q       <= '0;
         is_signed_q  <= 1'b0;
         busy         <= 1'b0;
         cmd_ready    <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  num_row_m1_q <= cmd_num_row_m1;
                  mask_q       <= cmd_col_mask;
                  is_signed_q  <= cmd_is_signed;
                  row_cnt      <= '0;
                  state        <= ST_STREAM;
                  busy         <= 1'b1;
                  cmd_ready    <= 1'b0;
               end
            end
            ST_STREAM: begin
               // The counter stops on the last row so a full-range count never wraps.
               if (tin_fire) begin
                  if (last_p0) state   <= ST_DRAIN;
                  else         row_cnt <= row_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   // Stage p1: buffered rows toward the write-data channel.
   dca_row_fifo #(
      .WIDTH (BW_FIFO_ENTRY),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .clk       (clk),
      .rstnn     (rstnn),
      .clear     (clear),
      .push      (tin_fire),
      .push_data (entry_p0),
      .pop       (wout_ready),
      .pop_data  (entry_p1),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign vld_p1                           = !fifo_empty;
   assign wout_valid                       = vld_p1;
   assign {wout_last, wout_strb, wout_row} = entry_p1;

endmodule
